// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its surroundings: hazard requests,
// ID-stage redirect operands, the instruction-memory port and the IF/ID outputs.
interface fetch_if;
  logic        BranchBubble;
  logic        LoadUseBubble;
  logic [2:0]  id_Branch;
  logic        id_BranchTaken;
  logic [1:0]  id_Jump;
  logic [15:0] id_Imm16;
  logic [25:0] id_Target26;
  logic [31:0] id_busA;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] id_Instruction;
  logic [31:0] id_PC4;
  logic        id_Valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output BranchBubble, LoadUseBubble, id_Branch, id_BranchTaken, id_Jump,
           id_Imm16, id_Target26, id_busA, imem_rdata,
    input  imem_addr, id_Instruction, id_PC4, id_Valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  BranchBubble, LoadUseBubble, id_Branch, id_BranchTaken, id_Jump,
           id_Imm16, id_Target26, id_busA, imem_rdata,
    output imem_addr, id_Instruction, id_PC4, id_Valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, redirects on taken branches/jumps decided in ID,
// holds on hazard bubbles, and registers the fetched word into IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [31:0] br_target(input logic [31:0] pc4, input logic [15:0] imm);
    logic signed [31:0] off;
    off = {{14{imm[15]}}, imm, 2'b00};
    return pc4 + off;
  endfunction

  logic [31:0] r_pc_p0;
  logic [31:0] r_instr_p1;
  logic [31:0] r_pc4_p1;
  logic        r_vld_p1;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic        w_stall;
  logic        w_take;
  logic        w_redirect;
  logic [31:0] w_pc4_p0;
  logic [31:0] w_target;

  assign w_stall    = bus.BranchBubble | bus.LoadUseBubble;
  assign w_take     = ((bus.id_Branch != 3'b000) & bus.id_BranchTaken)
                    | (bus.id_Jump == 2'b01) | (bus.id_Jump == 2'b10);
  assign w_redirect = ~w_stall & r_vld_p1 & w_take;
  assign w_pc4_p0   = r_pc_p0 + 32'd4;

  // A branch in ID takes precedence over any jump encoding alongside it.
  always_comb begin
    w_target = {r_pc4_p1[31:28], bus.id_Target26, 2'b00};
    if (bus.id_Branch != 3'b000)
      w_target = br_target(r_pc4_p1, bus.id_Imm16);
    else if (bus.id_Jump == 2'b10)
      w_target = {bus.id_busA[31:2], 2'b00};
  end

  // IF -> IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_p0     <= RESET_PC;
      r_instr_p1  <= 32'd0;
      r_pc4_p1    <= 32'd0;
      r_vld_p1    <= 1'b0;
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else if (w_stall) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end else if (w_redirect) begin
      r_pc_p0     <= w_target;
      r_instr_p1  <= 32'd0;
      r_pc4_p1    <= 32'd0;
      r_vld_p1    <= 1'b0;
      r_flush_cnt <= sat_inc(r_flush_cnt);
    end else begin
      r_pc_p0     <= w_pc4_p0;
      r_instr_p1  <= bus.imem_rdata;
      r_pc4_p1    <= w_pc4_p0;
      r_vld_p1    <= 1'b1;
    end
  end

  assign bus.imem_addr      = r_pc_p0;
  assign bus.id_Instruction = r_instr_p1;
  assign bus.id_PC4         = r_pc4_p1;
  assign bus.id_Valid       = r_vld_p1;
  assign bus.stall_cnt      = r_stall_cnt;
  assign bus.flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus ();
  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc = 0, m_instr = 0, m_pc4 = 0, m_scnt = 0, m_fcnt = 0;
  logic        m_vld = 0;

  task automatic idle();
    bus.BranchBubble = 0; bus.LoadUseBubble = 0;
    bus.id_Branch = 0; bus.id_BranchTaken = 0; bus.id_Jump = 0;
    bus.id_Imm16 = 0; bus.id_Target26 = 0; bus.id_busA = 0;
  endtask

  // Advance one clock, updating the reference model from the inputs seen at the edge.
  task automatic tick();
    logic stall, redir, r;
    logic [31:0] tgt;
    int off;
    stall = bus.BranchBubble | bus.LoadUseBubble;
    redir = !stall && m_vld && ((bus.id_Branch != 0 && bus.id_BranchTaken)
            || bus.id_Jump == 2'd1 || bus.id_Jump == 2'd2);
    off = $signed(bus.id_Imm16);
    if (bus.id_Branch != 0)      tgt = m_pc4 + 32'(off * 4);
    else if (bus.id_Jump == 2'd1) tgt = (m_pc4 & 32'hF000_0000) + {6'd0, bus.id_Target26} * 32'd4;
    else                          tgt = bus.id_busA & 32'hFFFF_FFFC;
    r = rst;
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_vld = 0; m_scnt = 0; m_fcnt = 0;
    end else if (stall) begin
      if (m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    end else if (redir) begin
      m_pc = tgt; m_instr = 0; m_pc4 = 0; m_vld = 0;
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
    end else begin
      m_instr = mem_word(m_pc); m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_vld = 1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    tick();
    bus.BranchBubble = 1;
    tick();
    n_vec++;
    if ({bus.imem_addr, bus.id_Instruction, bus.id_PC4, bus.id_Valid, bus.stall_cnt, bus.flush_cnt} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state got addr=%h ins=%h pc4=%h v=%b sc=%h fc=%h want all zero",
               bus.imem_addr, bus.id_Instruction, bus.id_PC4, bus.id_Valid, bus.stall_cnt, bus.flush_cnt);
    end
    idle(); rst = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if ({bus.imem_addr, bus.id_PC4, bus.id_Valid, bus.id_Instruction} !== {32'(4*i), 32'(4*i), 1'b1, mem_word(32'(4*(i-1)))}) begin
        n_err++;
        $display("FAIL free_run_%0d got addr=%h pc4=%h v=%b ins=%h want addr=%h pc4=%h v=1 ins=%h", i,
                 bus.imem_addr, bus.id_PC4, bus.id_Valid, bus.id_Instruction, 32'(4*i), 32'(4*i), mem_word(32'(4*(i-1))));
      end
    end
  endtask

  task automatic test_branch();
    tick();
    n_vec++;
    if (bus.id_PC4 !== 32'h10) begin n_err++; $display("FAIL br_setup got pc4=%h want 00000010", bus.id_PC4); end
    bus.id_Branch = 3'b001; bus.id_BranchTaken = 1; bus.id_Imm16 = 16'hFFFE;
    tick();
    n_vec++;
    if ({bus.imem_addr, bus.id_Instruction, bus.id_Valid, bus.flush_cnt} !== {32'h8, 32'h0, 1'b0, 32'h1}) begin
      n_err++;
      $display("FAIL br_taken got addr=%h ins=%h v=%b fc=%h want 00000008 00000000 0 00000001",
               bus.imem_addr, bus.id_Instruction, bus.id_Valid, bus.flush_cnt);
    end
    // Branch inputs still asserted, but IF/ID now holds the bubble: no second redirect.
    tick();
    n_vec++;
    if ({bus.imem_addr, bus.id_PC4, bus.id_Valid, bus.id_Instruction, bus.flush_cnt} !== {32'hC, 32'hC, 1'b1, mem_word(32'h8), 32'h1}) begin
      n_err++;
      $display("FAIL br_target_fetch got addr=%h pc4=%h v=%b ins=%h fc=%h want 0000000c 0000000c 1 %h 00000001",
               bus.imem_addr, bus.id_PC4, bus.id_Valid, bus.id_Instruction, bus.flush_cnt, mem_word(32'h8));
    end
    idle();
  endtask

  task automatic test_jump();
    bus.id_Jump = 2'b10; bus.id_busA = 32'h3000_0000;
    tick(); idle(); tick();
    n_vec++;
    if ({bus.id_PC4, bus.id_Valid} !== {32'h3000_0004, 1'b1}) begin
      n_err++; $display("FAIL j_setup got pc4=%h v=%b want 30000004 1", bus.id_PC4, bus.id_Valid);
    end
    bus.id_Jump = 2'b01; bus.id_Target26 = 26'h100;
    tick();
    n_vec++;
    if (bus.imem_addr !== 32'h3000_0400) begin
      n_err++; $display("FAIL j_target got addr=%h want 30000400", bus.imem_addr);
    end
    idle(); tick();
    bus.id_Jump = 2'b10; bus.id_busA = 32'h1237;
    tick();
    n_vec++;
    if ({bus.imem_addr, bus.id_Valid} !== {32'h1234, 1'b0}) begin
      n_err++; $display("FAIL jr_target got addr=%h v=%b want 00001234 0", bus.imem_addr, bus.id_Valid);
    end
    idle(); tick();
    bus.id_Branch = 3'b011; bus.id_BranchTaken = 1; bus.id_Imm16 = 16'h0004;
    bus.id_Jump = 2'b10; bus.id_busA = 32'hDEAD_0000;
    tick();
    n_vec++;
    if ({bus.imem_addr, bus.flush_cnt} !== {32'h1248, 32'h5}) begin
      n_err++; $display("FAIL branch_wins got addr=%h fc=%h want 00001248 00000005", bus.imem_addr, bus.flush_cnt);
    end
    idle(); tick();
  endtask

  task automatic test_stall_redirect();
    bus.id_Jump = 2'b10; bus.id_busA = 32'h500; bus.BranchBubble = 1;
    for (int i = 1; i <= 2; i++) begin
      tick();
      n_vec++;
      if ({bus.imem_addr, bus.id_PC4, bus.id_Valid, bus.stall_cnt, bus.flush_cnt} !== {m_pc, m_pc4, 1'b1, 32'(i), 32'h5}) begin
        n_err++;
        $display("FAIL stall_hold_%0d got addr=%h pc4=%h v=%b sc=%h fc=%h want %h %h 1 %h 00000005", i,
                 bus.imem_addr, bus.id_PC4, bus.id_Valid, bus.stall_cnt, bus.flush_cnt, m_pc, m_pc4, 32'(i));
      end
    end
    bus.BranchBubble = 0;
    tick();
    n_vec++;
    if ({bus.imem_addr, bus.id_Valid, bus.stall_cnt, bus.flush_cnt} !== {32'h500, 1'b0, 32'h2, 32'h6}) begin
      n_err++;
      $display("FAIL stall_then_redirect got addr=%h v=%b sc=%h fc=%h want 00000500 0 00000002 00000006",
               bus.imem_addr, bus.id_Valid, bus.stall_cnt, bus.flush_cnt);
    end
    idle(); tick();
  endtask

  task automatic test_wrap_reset();
    bus.id_Jump = 2'b10; bus.id_busA = 32'hFFFF_FFFF;
    tick();
    n_vec++;
    if (bus.imem_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL wrap_setup got addr=%h want fffffffc", bus.imem_addr);
    end
    idle(); tick();
    n_vec++;
    if ({bus.imem_addr, bus.id_PC4, bus.id_Valid, bus.id_Instruction} !== {32'h0, 32'h0, 1'b1, mem_word(32'hFFFF_FFFC)}) begin
      n_err++;
      $display("FAIL pc_wrap got addr=%h pc4=%h v=%b ins=%h want 00000000 00000000 1 %h",
               bus.imem_addr, bus.id_PC4, bus.id_Valid, bus.id_Instruction, mem_word(32'hFFFF_FFFC));
    end
    bus.LoadUseBubble = 1;
    tick();
    rst = 1; bus.id_Jump = 2'b10; bus.id_busA = 32'h40;
    tick();
    n_vec++;
    if ({bus.imem_addr, bus.id_Instruction, bus.id_PC4, bus.id_Valid, bus.stall_cnt, bus.flush_cnt} !== {32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_mid_stall got addr=%h ins=%h pc4=%h v=%b sc=%h fc=%h want all zero",
               bus.imem_addr, bus.id_Instruction, bus.id_PC4, bus.id_Valid, bus.stall_cnt, bus.flush_cnt);
    end
    rst = 0; idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.BranchBubble   = ($urandom_range(0, 4) == 0);
      bus.LoadUseBubble  = ($urandom_range(0, 5) == 0);
      bus.id_Branch      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      bus.id_BranchTaken = 1'($urandom);
      bus.id_Jump        = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      bus.id_Imm16       = 16'($urandom);
      bus.id_Target26    = 26'($urandom);
      bus.id_busA        = $urandom;
      if (bus.id_Branch != 0 && !bus.id_BranchTaken && (bus.id_Jump == 2'd1 || bus.id_Jump == 2'd2))
        bus.id_Jump = 2'd0;
      tick();
      n_vec++;
      if ({bus.imem_addr, bus.id_Instruction, bus.id_PC4, bus.id_Valid, bus.stall_cnt, bus.flush_cnt} !== {m_pc, m_instr, m_pc4, m_vld, m_scnt, m_fcnt}) begin
        n_err++;
        $display("FAIL random_%0d got addr=%h ins=%h pc4=%h v=%b sc=%h fc=%h want %h %h %h %b %h %h", c,
                 bus.imem_addr, bus.id_Instruction, bus.id_PC4, bus.id_Valid, bus.stall_cnt, bus.flush_cnt,
                 m_pc, m_instr, m_pc4, m_vld, m_scnt, m_fcnt);
      end
    end
    rst = 0; idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_branch();
    test_jump();
    test_stall_redirect();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
